// File: rtl/funct_seq_pkg.sv
// Opcode/funct encodings shared by the ID-stage ALU function generator and its decoder.
// FSM state constants for the multiply/divide sequencer live here too.
package funct_seq_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_NOP   = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/funct_seq_decode.sv
// Combinational opcode/funct to ALU funct decode, plus HI/LO classification.
// Zero latency; no flow control of its own.
module funct_decode
  import funct_seq_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  output logic [FUNCT_W-1:0] funct,
  output logic               is_md,
  output logic               is_div,
  output logic               hilo_dep
);

  logic special;
  logic md_range;
  logic mfmt_range;
  logic div_code;

  assign special    = (op == OP_W'(OP_SPECIAL));
  assign md_range   = (funct_in >= FUNCT_W'(F_MULT)) && (funct_in <= FUNCT_W'(F_DIVU));
  assign mfmt_range = (funct_in >= FUNCT_W'(F_MFHI)) && (funct_in <= FUNCT_W'(F_MTLO));
  assign div_code   = (funct_in == FUNCT_W'(F_DIV)) || (funct_in == FUNCT_W'(F_DIVU));

  assign is_md    = special && md_range;
  assign is_div   = special && div_code;
  assign hilo_dep = special && (md_range || mfmt_range);

  always_comb begin
    funct = FUNCT_W'(F_NOP);
    case (op)
      OP_W'(OP_SPECIAL): funct = funct_in;
      OP_W'(OP_LUI), OP_W'(OP_ORI), OP_W'(OP_JAL): funct = FUNCT_W'(F_OR);
      OP_W'(OP_LB), OP_W'(OP_LH), OP_W'(OP_LW), OP_W'(OP_LBU), OP_W'(OP_LHU),
      OP_W'(OP_SB), OP_W'(OP_SH), OP_W'(OP_SW), OP_W'(OP_ADDIU): funct = FUNCT_W'(F_ADDU);
      OP_W'(OP_ANDI):  funct = FUNCT_W'(F_AND);
      OP_W'(OP_XORI):  funct = FUNCT_W'(F_XOR);
      OP_W'(OP_ADDI):  funct = FUNCT_W'(F_ADD);
      OP_W'(OP_SLTI):  funct = FUNCT_W'(F_SLT);
      OP_W'(OP_SLTIU): funct = FUNCT_W'(F_SLTU);
      default:         funct = FUNCT_W'(F_NOP);
    endcase
  end

endmodule

// File: rtl/funct_seq.sv
// ID/EX ALU funct register with a fixed-latency MULT/DIV sequencer; 1-cycle decode-to-output.
// Only HI/LO-dependent instructions stall while an op is in flight; flush squashes acceptance.
module funct_seq
  import funct_seq_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  input  logic               flush,
  output logic               stall_req,
  output logic [FUNCT_W-1:0] funct_out,
  output logic               funct_valid,
  output logic               md_start,
  output logic               md_busy,
  output logic               md_done
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [FUNCT_W-1:0] dec_funct;
  logic               dec_is_md;
  logic               dec_is_div;
  logic               dec_hilo_dep;

  funct_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .op       (op),
    .funct_in (funct_in),
    .funct    (dec_funct),
    .is_md    (dec_is_md),
    .is_div   (dec_is_div),
    .hilo_dep (dec_hilo_dep)
  );

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FUNCT_W-1:0] funct_out_q, funct_out_d;
  logic               funct_valid_q, funct_valid_d;
  logic               md_start_q, md_start_d;
  logic               accept;

  assign md_busy   = (state_q == ST_BUSY);
  assign md_done   = md_busy && (cnt_q == '0);
  // The done cycle releases the stall so a dependent op lands right behind the result.
  assign stall_req = valid_in && dec_hilo_dep && md_busy && !md_done;
  assign accept    = valid_in && !flush && !stall_req;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    funct_out_d   = accept ? dec_funct : FUNCT_W'(F_NOP);
    funct_valid_d = accept;
    md_start_d    = accept && dec_is_md;
    if (state_q == ST_BUSY) begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    // A new issue overrides the done-cycle return to IDLE (back-to-back).
    if (accept && dec_is_md) begin
      state_d = ST_BUSY;
      cnt_d   = dec_is_div ? DIV_LOAD : MUL_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      funct_out_q   <= '0;
      funct_valid_q <= 1'b0;
      md_start_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      funct_out_q   <= funct_out_d;
      funct_valid_q <= funct_valid_d;
      md_start_q    <= md_start_d;
    end
  end

  assign funct_out   = funct_out_q;
  assign funct_valid = funct_valid_q;
  assign md_start    = md_start_q;

endmodule

// File: tb/tb_funct_seq.sv
// Directed plus random stimulus for funct_seq, checked against a cycle-number based reference model.
module tb_funct_seq;

  localparam int MUL = 4;
  localparam int DIV = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] op = 6'h00;
  logic [5:0] funct_in = 6'h00;
  logic       stall_req, funct_valid, md_start, md_busy, md_done;
  logic [5:0] funct_out;

  funct_seq #(
    .OP_W       (6),
    .FUNCT_W    (6),
    .MUL_CYCLES (MUL),
    .DIV_CYCLES (DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .op          (op),
    .funct_in    (funct_in),
    .flush       (flush),
    .stall_req   (stall_req),
    .funct_out   (funct_out),
    .funct_valid (funct_valid),
    .md_start    (md_start),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: absolute cycle numbers of the last issue and its latency.
  int         cyc     = 0;
  bit         have_op = 1'b0;
  int         iss     = 0;
  int         lat     = 0;
  logic [5:0] exp_f   = 6'h00;
  logic       exp_v   = 1'b0;

  function automatic logic [5:0] ref_dec(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:                      return f;
      6'h0F, 6'h0D, 6'h03:        return 6'h25;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2B, 6'h09: return 6'h21;
      6'h0C:                      return 6'h24;
      6'h0E:                      return 6'h26;
      6'h08:                      return 6'h20;
      6'h0A:                      return 6'h2A;
      6'h0B:                      return 6'h2B;
      default:                    return 6'h00;
    endcase
  endfunction

  function automatic bit ref_md(input logic [5:0] o, input logic [5:0] f);
    return (o == 6'h00) && (f >= 6'h18) && (f <= 6'h1B);
  endfunction

  function automatic bit ref_dep(input logic [5:0] o, input logic [5:0] f);
    return ref_md(o, f) || ((o == 6'h00) && (f >= 6'h10) && (f <= 6'h13));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One ID cycle: drive, check this cycle's outputs, then advance the model across the edge.
  task automatic step(input logic v, input logic [5:0] o, input logic [5:0] f, input logic fl);
    bit b, d, s, st, acc;
    @(negedge clk);
    valid_in = v; op = o; funct_in = f; flush = fl;
    #1;
    b  = have_op && (cyc > iss) && (cyc <= iss + lat);
    d  = have_op && (cyc == iss + lat);
    s  = have_op && (cyc == iss + 1);
    st = v && ref_dep(o, f) && b && !d;
    chk("funct_out",   funct_out,   exp_f);
    chk("funct_valid", funct_valid, exp_v);
    chk("md_start",    md_start,    s);
    chk("md_busy",     md_busy,     b);
    chk("md_done",     md_done,     d);
    chk("stall_req",   stall_req,   st);
    acc = v && !fl && !st;
    @(posedge clk);
    exp_f = acc ? ref_dec(o, f) : 6'h00;
    exp_v = acc;
    if (acc && ref_md(o, f)) begin
      have_op = 1'b1;
      iss     = cyc;
      lat     = (f == 6'h1A || f == 6'h1B) ? DIV : MUL;
    end
    cyc++;
  endtask

  task automatic async_reset();
    @(negedge clk);
    valid_in = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_funct_out",   funct_out,   0);
    chk("rst_funct_valid", funct_valid, 0);
    chk("rst_md_start",    md_start,    0);
    chk("rst_md_busy",     md_busy,     0);
    chk("rst_md_done",     md_done,     0);
    chk("rst_stall_req",   stall_req,   0);
    rst_n = 1'b1;
    @(posedge clk);
    have_op = 1'b0; exp_f = 6'h00; exp_v = 1'b0;
    cyc++;
  endtask

  logic [5:0] dec_ops [20] = '{6'h0F, 6'h0D, 6'h03, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                               6'h28, 6'h29, 6'h2B, 6'h09, 6'h0C, 6'h0E, 6'h08, 6'h0A,
                               6'h0B, 6'h3F, 6'h00, 6'h01};
  logic [5:0] sp_f [8] = '{6'h10, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h21, 6'h2A};

  initial begin
    #2;
    chk("init_funct_out",   funct_out,   0);
    chk("init_funct_valid", funct_valid, 0);
    chk("init_md_start",    md_start,    0);
    chk("init_md_busy",     md_busy,     0);
    chk("init_md_done",     md_done,     0);
    #10 rst_n = 1'b1;

    // Full decode table, including an unlisted opcode.
    foreach (dec_ops[i]) step(1'b1, dec_ops[i], (dec_ops[i] == 6'h00) ? 6'h21 : 6'($urandom), 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0);

    // DIV with unrelated ADDU traffic across its whole latency.
    step(1'b1, 6'h00, 6'h1A, 1'b0);
    for (int i = 0; i < DIV; i++) step(1'b1, 6'h00, 6'h21, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0);

    // MULT followed by a held MFLO.
    step(1'b1, 6'h00, 6'h18, 1'b0);
    for (int i = 0; i < MUL; i++) step(1'b1, 6'h00, 6'h12, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0);

    // Back-to-back MULTU issued in the done cycle.
    step(1'b1, 6'h00, 6'h19, 1'b0);
    for (int i = 1; i < MUL; i++) step(1'b0, 6'h00, 6'h00, 1'b0);
    step(1'b1, 6'h00, 6'h19, 1'b0);
    for (int i = 0; i < MUL + 2; i++) step(1'b0, 6'h00, 6'h00, 1'b0);

    // Flush of an md op, then flush while busy.
    step(1'b1, 6'h00, 6'h18, 1'b1);
    step(1'b0, 6'h00, 6'h00, 1'b0);
    step(1'b1, 6'h00, 6'h18, 1'b0);
    step(1'b1, 6'h00, 6'h12, 1'b1);
    step(1'b1, 6'h23, 6'h00, 1'b1);
    for (int i = 0; i < MUL; i++) step(1'b0, 6'h00, 6'h00, 1'b0);

    // Reset while a DIV has ten cycles left.
    step(1'b1, 6'h00, 6'h1B, 1'b0);
    for (int i = 0; i < DIV - 11; i++) step(1'b0, 6'h00, 6'h00, 1'b0);
    async_reset();
    step(1'b1, 6'h23, 6'h00, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0);

    // Random mix biased toward HI/LO traffic.
    for (int i = 0; i < 400; i++) begin
      logic v, fl;
      logic [5:0] o, f;
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) != 0) begin
        o = 6'h00;
        f = sp_f[$urandom_range(0, 7)];
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      step(v, o, f, fl);
    end
    step(1'b0, 6'h00, 6'h00, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/funct_seq.md
# funct_seq

Parametrised ID-stage ALU function generator with a multi-cycle multiply/divide sequencer.
- Decodes opcode/funct into the 6-bit ALU funct code and registers it into the ID/EX boundary.
- Issues MULT/MULTU/DIV/DIVU to the HI/LO unit and tracks their fixed latency.
- Stalls only instructions that depend on HI/LO while an operation is in flight; all other instructions flow.

## Interface
Parameters:
- OP_W, 6, opcode width
- FUNCT_W, 6, funct width
- MUL_CYCLES, 4, multiply latency in cycles, ≥1
- DIV_CYCLES, 32, divide latency in cycles, ≥1
- CNT_W, $clog2(max(MUL_CYCLES,DIV_CYCLES)+1), counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  ID holds a valid instruction
- op  in  OP_W  instruction opcode
- funct_in  in  FUNCT_W  instruction funct field
- flush  in  1  squash the ID instruction (branch/exception)
- stall_req  out  1  combinational; ID instruction must hold this cycle
- funct_out  out  FUNCT_W  registered ALU funct to EX
- funct_valid  out  1  registered; funct_out is live
- md_start  out  1  one-cycle pulse; HI/LO unit begins the op in funct_out
- md_busy  out  1  multiply/divide in flight
- md_done  out  1  one-cycle pulse; result written to HI/LO at end of this cycle

## Operation
- Decode table (combinational):
  - SPECIAL (0x00) → funct_in
  - LUI 0x0F, ORI 0x0D, JAL 0x03 → OR 0x25
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B, ADDIU 0x09 → ADDU 0x21
  - ANDI 0x0C → AND 0x24
  - XORI 0x0E → XOR 0x26
  - ADDI 0x08 → ADD 0x20
  - SLTI 0x0A → SLT 0x2A
  - SLTIU 0x0B → SLTU 0x2B
  - any other opcode → NOP 0x00
- md op: SPECIAL with funct 0x18–0x1B. hilo_dep: md op, or SPECIAL with funct 0x10–0x13 (MFHI/MTHI/MFLO/MTLO).
- Accept condition: valid_in & !flush & !stall_req. On accept, funct_out ← decoded value and funct_valid ← 1. Otherwise funct_out ← 0x00 and funct_valid ← 0 (bubble).
- FSM states: IDLE, BUSY.
  - IDLE → BUSY on accept of an md op. md_start=1 next cycle. cnt ← MUL_CYCLES−1 for MULT/MULTU, DIV_CYCLES−1 for DIV/DIVU.
  - In BUSY: cnt decrements each cycle. md_done = BUSY & (cnt==0). On that cycle the state returns to IDLE.
- md_busy = (state==BUSY).
- stall_req = valid_in & hilo_dep & md_busy & !md_done.
- A new md op may be accepted in the md_done cycle. The state then reloads BUSY with the new count (back-to-back issue).
- flush does not abort an in-flight operation; it only suppresses acceptance.

## Timing
- Reset values: state IDLE, cnt 0, funct_out 0x00, funct_valid 0, md_start 0, md_busy 0, md_done 0.
- Decode-to-output latency: 1 cycle.
- md op accepted at cycle T:
  - md_start and md_busy high at T+1.
  - md_done at T+LAT.
  - md_busy low at T+LAT+1 unless re-issued.
- With LAT=1: md_start and md_done coincide at T+1.
- A hilo_dep instruction at ID during T+1..T+LAT−1 stalls. It is accepted at T+LAT, with funct_valid at T+LAT+1.
- flush and stall_req together: flush wins; a bubble is emitted.
- rst_n asserted mid-operation: everything returns to reset values immediately (asynchronous); no md_done is issued.

## Structure
- Opcode and funct constants (including the new ADD/SLT/SLTU and the MULT/DIV/MF/MT codes) belong in the shared opcode/funct include headers. Nothing is defined locally.
- Sub-module funct_decode: purely combinational op/funct_in → funct, is_md, is_div, hilo_dep.
- funct_seq holds the output register, FSM, counter and stall logic.

## Test plan
- Reset while BUSY with cnt=10 → all outputs 0 and state IDLE at once. After release, a non-md op flows with 1-cycle latency.
- Every opcode in the decode table plus opcode 0x3F, valid_in=1 → funct_out matches the table one cycle later. 0x3F gives 0x00.
- DIV (funct 0x1A), DIV_CYCLES=32, accepted at T=5 → md_start at 6, md_done at 37, md_busy low at 38. ADDU issued at 6..37 is never stalled.
- MULT at T, then MFLO held at ID from T+1 (MUL_CYCLES=4) → stall_req high T+1..T+3, low at T+4; funct_out=0x12 valid at T+5.
- Back-to-back MULTU issued in the md_done cycle → md_start next cycle, md_busy never drops, second md_done exactly MUL_CYCLES later.
- flush with a valid MULT at ID → funct_valid=0, no md_start. flush during BUSY leaves the existing md_done timing unchanged.
